// File: rtl/envelope_ramp_pkg.sv
// Shared types and default geometry for the ramping gain envelope.
package envelope_ramp_pkg;

    localparam int unsigned ENV_N_STAGES = 8;
    localparam int unsigned ENV_GAIN_W   = 8;
    localparam int unsigned ENV_DUR_W    = 32;
    localparam int unsigned ENV_FRAC_W   = 16;
    localparam int unsigned ENV_STG_W    = $clog2(ENV_N_STAGES);

    // Bit of the wavegen command register that drives loop_en.
    localparam int unsigned ENVELOPE_LOOP_BIT = 3;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_SETUP,
        ENV_RAMP,
        ENV_SUSTAIN,
        ENV_DONE
    } env_state_t;

    typedef struct packed {
        logic [ENV_N_STAGES-1:0][ENV_GAIN_W-1:0] gains;
        logic [ENV_N_STAGES-1:0][ENV_DUR_W-1:0]  durations;
        logic [ENV_STG_W-1:0]                    sustain_idx;
        logic                                    loop_en;
    } envelope_ramp_cfg_t;

endpackage

// File: rtl/envelope_ramp_seq_divider.sv
// Restoring unsigned sequential divider, one quotient bit per clock.
module envelope_ramp_seq_divider #(
    parameter int unsigned NUM_W = 24,
    parameter int unsigned DEN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DEN_W:0]   rem_sh;
    logic [DEN_W:0]   rem_sub;

    // Shift-subtract iteration; a zero divisor naturally yields all-ones.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_sh  = {rem_q, quo_q[NUM_W-1]};
        rem_sub = rem_sh - {1'b0, den_q};
        if (start) begin
            rem_d  = '0;
            quo_d  = num;
            den_d  = den;
            cnt_d  = CNT_W'(NUM_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = {quo_q[NUM_W-2:0], 1'b0};
            if (rem_sh >= {1'b0, den_q}) begin
                rem_d    = rem_sub[DEN_W-1:0];
                quo_d[0] = 1'b1;
            end else begin
                rem_d = rem_sh[DEN_W-1:0];
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/envelope_ramp.sv
// N-stage gain envelope that ramps linearly to each stage target on sample_tick,
// with gate-driven sustain, release and optional attack/decay looping.
module envelope_ramp
    import envelope_ramp_pkg::*;
#(
    parameter int unsigned N_STAGES = ENV_N_STAGES,
    parameter int unsigned GAIN_W   = ENV_GAIN_W,
    parameter int unsigned DUR_W    = ENV_DUR_W,
    parameter int unsigned FRAC_W   = ENV_FRAC_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sample_tick,
    input  logic                               gate,
    input  logic                               env_reset,
    input  logic [N_STAGES-1:0][GAIN_W-1:0]    gains,
    input  logic [N_STAGES-1:0][DUR_W-1:0]     durations,
    input  logic [$clog2(N_STAGES)-1:0]        sustain_idx,
    input  logic                               loop_en,
    output logic [GAIN_W+FRAC_W-1:0]           level,
    output logic [$clog2(N_STAGES)-1:0]        stage,
    output logic                               active,
    output logic                               done
);

    localparam int unsigned LVL_W = GAIN_W + FRAC_W;
    localparam int unsigned STG_W = $clog2(N_STAGES);
    localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(N_STAGES - 1);
    localparam logic [LVL_W-1:0] LVL_MAX    = '1;

    env_state_t       state_q, state_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] target_q, target_d;
    logic [LVL_W-1:0] step_q, step_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] elapsed_q, elapsed_d;
    logic [STG_W-1:0] sus_q, sus_d;
    logic             loop_q, loop_d;
    logic             down_q, down_d;
    logic             launched_q, launched_d;
    logic             gate_q, gate_d;
    logic             done_q, done_d;
    logic             active_q, active_d;

    logic             gate_rise, gate_fall;
    logic             advance, go_setup;
    logic [STG_W-1:0] go_stage;
    logic [LVL_W-1:0] t_new;
    logic [DUR_W-1:0] elapsed_n;
    logic [LVL_W:0]   sum;
    logic             div_start_c, div_clr_c, div_busy, div_done;
    logic [LVL_W-1:0] div_num_c, div_quo;

    assign div_clr_c = rst || env_reset;

    envelope_ramp_seq_divider #(
        .NUM_W (LVL_W),
        .DEN_W (DUR_W)
    ) u_div (
        .clk      (clk),
        .rst      (div_clr_c),
        .start    (div_start_c),
        .num      (div_num_c),
        .den      (durations[stage_q]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        level_d     = level_q;
        target_d    = target_q;
        step_d      = step_q;
        dur_d       = dur_q;
        elapsed_d   = elapsed_q;
        sus_d       = sus_q;
        loop_d      = loop_q;
        down_d      = down_q;
        launched_d  = launched_q;
        gate_d      = gate;
        done_d      = 1'b0;
        advance     = 1'b0;
        go_setup    = 1'b0;
        go_stage    = '0;
        div_start_c = 1'b0;
        div_num_c   = '0;
        t_new       = {gains[stage_q], {FRAC_W{1'b0}}};
        elapsed_n   = elapsed_q + DUR_W'(1);
        sum         = {1'b0, level_q} + {1'b0, step_q};
        gate_rise   = gate && !gate_q;
        gate_fall   = !gate && gate_q;

        if (env_reset) begin
            state_d    = ENV_IDLE;
            stage_d    = '0;
            level_d    = '0;
            elapsed_d  = '0;
            launched_d = 1'b0;
        end else begin
            case (state_q)
                ENV_IDLE, ENV_DONE: begin
                    if (gate_rise) begin
                        go_setup = 1'b1;
                    end
                end
                default: begin
                    // Gate edges outrank ticks; release begins from wherever level is.
                    if (gate_fall && stage_q <= sus_q) begin
                        if (sus_q == LAST_STAGE) begin
                            state_d = ENV_DONE;
                            done_d  = 1'b1;
                        end else begin
                            go_setup = 1'b1;
                            go_stage = sus_q + STG_W'(1);
                        end
                    end else if (gate_rise && stage_q > sus_q) begin
                        go_setup = 1'b1;
                    end else if (state_q == ENV_SETUP) begin
                        if (!launched_q) begin
                            launched_d = 1'b1;
                            target_d   = t_new;
                            dur_d      = durations[stage_q];
                            sus_d      = sustain_idx;
                            loop_d     = loop_en;
                            elapsed_d  = DUR_W'(sample_tick);
                            if (durations[stage_q] == '0) begin
                                level_d = t_new;
                                advance = 1'b1;
                            end else begin
                                div_start_c = 1'b1;
                                down_d      = t_new < level_q;
                                div_num_c   = (t_new < level_q) ? (level_q - t_new)
                                                                : (t_new - level_q);
                            end
                        end else begin
                            if (sample_tick) begin
                                elapsed_d = elapsed_n;
                            end
                            if (div_done && !div_busy) begin
                                step_d = div_quo;
                                // Ticks seen during the divide may already exhaust the stage.
                                if (elapsed_d >= dur_q) begin
                                    level_d = target_q;
                                    advance = 1'b1;
                                end else begin
                                    state_d = ENV_RAMP;
                                end
                            end
                        end
                    end else if (state_q == ENV_RAMP && sample_tick) begin
                        elapsed_d = elapsed_n;
                        if (elapsed_n >= dur_q) begin
                            level_d = target_q;
                            advance = 1'b1;
                        end else if (down_q) begin
                            level_d = (level_q < step_q) ? '0 : (level_q - step_q);
                        end else begin
                            level_d = sum[LVL_W] ? LVL_MAX : sum[LVL_W-1:0];
                        end
                    end
                end
            endcase

            if (advance) begin
                if (stage_q == sus_d && gate_q && !loop_d) begin
                    state_d = ENV_SUSTAIN;
                end else if (stage_q == sus_d && gate_q) begin
                    go_setup = 1'b1;
                end else if (stage_q == LAST_STAGE) begin
                    state_d = ENV_DONE;
                    done_d  = 1'b1;
                end else begin
                    go_setup = 1'b1;
                    go_stage = stage_q + STG_W'(1);
                end
            end

            if (go_setup) begin
                state_d    = ENV_SETUP;
                stage_d    = go_stage;
                launched_d = 1'b0;
            end
        end

        active_d = (state_d == ENV_RAMP) || (state_d == ENV_SUSTAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ENV_IDLE;
            stage_q    <= '0;
            level_q    <= '0;
            target_q   <= '0;
            step_q     <= '0;
            dur_q      <= '0;
            elapsed_q  <= '0;
            sus_q      <= '0;
            loop_q     <= 1'b0;
            down_q     <= 1'b0;
            launched_q <= 1'b0;
            // Track gate through reset so a gate raised under reset is not seen as an edge.
            gate_q     <= gate;
            done_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            level_q    <= level_d;
            target_q   <= target_d;
            step_q     <= step_d;
            dur_q      <= dur_d;
            elapsed_q  <= elapsed_d;
            sus_q      <= sus_d;
            loop_q     <= loop_d;
            down_q     <= down_d;
            launched_q <= launched_d;
            gate_q     <= gate_d;
            done_q     <= done_d;
            active_q   <= active_d;
        end
    end

    assign level  = level_q;
    assign stage  = stage_q;
    assign active = active_q;
    assign done   = done_q;

endmodule

// File: tb/tb_envelope_ramp.sv
// Directed bench for envelope_ramp: ramps, truncation, sustain/release, looping, resets.
module tb_envelope_ramp;
    import envelope_ramp_pkg::*;

    localparam int unsigned LW = ENV_GAIN_W + ENV_FRAC_W;
    localparam int unsigned SW = ENV_STG_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_tick;
    logic               gate;
    logic               env_reset;
    envelope_ramp_cfg_t cfg;
    logic [LW-1:0]      level;
    logic [SW-1:0]      stage;
    logic               active;
    logic               done;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int s1_entries  = 0;
    logic [SW-1:0] stage_prev = '0;
    int base;

    always #5 clk = ~clk;

    envelope_ramp dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .gate        (gate),
        .env_reset   (env_reset),
        .gains       (cfg.gains),
        .durations   (cfg.durations),
        .sustain_idx (cfg.sustain_idx),
        .loop_en     (cfg.loop_en),
        .level       (level),
        .stage       (stage),
        .active      (active),
        .done        (done)
    );

    always @(posedge clk) begin
        if (done) done_cnt++;
        if (stage == SW'(1) && stage_prev != SW'(1)) s1_entries++;
        stage_prev = stage;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fx(input int g);
        return 32'(g) << ENV_FRAC_W;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sample period of 64 clocks with the tick in the first.
    task automatic tick();
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        cycles(62);
    endtask

    task automatic env_restart();
        @(negedge clk);
        gate      = 1'b0;
        env_reset = 1'b1;
        @(negedge clk) env_reset = 1'b0;
        cycles(2);
    endtask

    task automatic gate_on();
        @(negedge clk) gate = 1'b1;
        cycles(40);
    endtask

    task automatic cfg_clear();
        for (int i = 0; i < ENV_N_STAGES; i++) begin
            cfg.gains[i]     = '0;
            cfg.durations[i] = 32'd1000;
        end
        cfg.sustain_idx = SW'(ENV_N_STAGES - 1);
        cfg.loop_en     = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        gate        = 1'b0;
        sample_tick = 1'b0;
        env_reset   = 1'b0;
        cfg         = '0;
        cfg_clear();
        cycles(3);
        @(negedge clk) rst = 1'b0;
        cycles(1);
        check_val("rst_level", 32'(level), 0);
        check_val("rst_stage", 32'(stage), 0);
        check_val("rst_active", 32'(active), 0);
        check_val("rst_done", 32'(done), 0);

        // Exact linear ramp 0 -> 100 over 4 samples
        cfg.gains[0]     = 8'd100;
        cfg.durations[0] = 32'd4;
        gate_on();
        check_val("t1_active", 32'(active), 1);
        check_val("t1_level0", 32'(level), 0);
        tick(); check_val("t1_tick1", 32'(level), fx(25));
        tick(); check_val("t1_tick2", 32'(level), fx(50));
        tick(); check_val("t1_tick3", 32'(level), fx(75));
        check_val("t1_stage_pre", 32'(stage), 0);
        tick(); check_val("t1_tick4", 32'(level), fx(100));
        check_val("t1_stage", 32'(stage), 1);

        // Truncated step, exact landing on the target
        env_restart();
        cfg_clear();
        cfg.gains[0]     = 8'd10;
        cfg.durations[0] = 32'd3;
        gate_on();
        tick(); check_val("t2_tick1", 32'(level), 32'd218453);
        tick(); check_val("t2_tick2", 32'(level), 32'd436906);
        tick(); check_val("t2_tick3", 32'(level), fx(10));

        // Sustain, release and completion
        env_restart();
        cfg_clear();
        cfg.gains[0] = 8'd10; cfg.gains[1] = 8'd20; cfg.gains[2] = 8'd30;
        cfg.durations[0] = 32'd2; cfg.durations[1] = 32'd2; cfg.durations[2] = 32'd2;
        cfg.durations[3] = 32'd4;
        for (int i = 4; i < ENV_N_STAGES; i++) cfg.durations[i] = 32'd1;
        cfg.sustain_idx = SW'(2);
        gate_on();
        tick(); tick(); check_val("t3_s0_end", 32'(level), fx(10));
        tick(); tick(); tick(); tick();
        check_val("t3_sus_level", 32'(level), fx(30));
        check_val("t3_sus_stage", 32'(stage), 2);
        check_val("t3_sus_active", 32'(active), 1);
        tick(); check_val("t3_sus_hold", 32'(level), fx(30));
        @(negedge clk) gate = 1'b0;
        cycles(40);
        check_val("t3_rel_stage", 32'(stage), 3);
        check_val("t3_rel_start", 32'(level), fx(30));
        tick(); check_val("t3_rel1", 32'(level), 32'd1474560);
        tick(); check_val("t3_rel2", 32'(level), 32'd983040);
        tick(); check_val("t3_rel3", 32'(level), 32'd491520);
        tick(); check_val("t3_rel4", 32'(level), 0);
        check_val("t3_stage4", 32'(stage), 4);
        base = done_cnt;
        tick(); tick(); tick();
        check_val("t3_stage7", 32'(stage), 7);
        check_val("t3_no_done_yet", 32'(done_cnt - base), 0);
        tick();
        check_val("t3_done_pulses", 32'(done_cnt - base), 1);
        check_val("t3_done_active", 32'(active), 0);
        check_val("t3_done_level", 32'(level), 0);

        // Gate dropped mid-attack: release from current level
        env_restart();
        gate_on();
        tick(); tick(); tick();
        check_val("t4_mid_level", 32'(level), fx(15));
        check_val("t4_mid_stage", 32'(stage), 1);
        @(negedge clk) gate = 1'b0;
        cycles(40);
        check_val("t4_rel_stage", 32'(stage), 3);
        check_val("t4_no_jump", 32'(level), fx(15));
        tick(); check_val("t4_rel1", 32'(level), 32'd737280);

        // Looping with a zero-length stage
        env_restart();
        cfg_clear();
        cfg.gains[0] = 8'd40; cfg.durations[0] = 32'd2;
        cfg.gains[1] = 8'd80; cfg.durations[1] = 32'd0;
        cfg.sustain_idx = SW'(1);
        cfg.loop_en     = 1'b1;
        base = s1_entries;
        gate_on();
        tick(); check_val("t5_tick1", 32'(level), fx(20));
        tick(); check_val("t5_snap", 32'(level), fx(80));
        check_val("t5_wrap_stage", 32'(stage), 0);
        check_val("t5_s1_visits1", 32'(s1_entries - base), 1);
        tick(); check_val("t5_tick3", 32'(level), fx(60));
        tick(); check_val("t5_snap2", 32'(level), fx(80));
        check_val("t5_s1_visits2", 32'(s1_entries - base), 2);

        // env_reset mid-ramp, then rst coincident with a gate edge
        env_restart();
        cfg_clear();
        cfg.gains[0]     = 8'd100;
        cfg.durations[0] = 32'd4;
        gate_on();
        tick(); tick(); check_val("t6_pre", 32'(level), fx(50));
        @(negedge clk) env_reset = 1'b1;
        @(negedge clk) env_reset = 1'b0;
        check_val("t6_er_level", 32'(level), 0);
        check_val("t6_er_active", 32'(active), 0);
        check_val("t6_er_stage", 32'(stage), 0);
        cycles(40);
        check_val("t6_er_stay", 32'(active), 0);
        @(negedge clk) gate = 1'b0;
        cycles(3);
        @(negedge clk);
        rst  = 1'b1;
        gate = 1'b1;
        @(negedge clk) rst = 1'b0;
        cycles(40);
        check_val("t6_rst_active", 32'(active), 0);
        check_val("t6_rst_level", 32'(level), 0);
        check_val("t6_rst_stage", 32'(stage), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/envelope_ramp.md
Name: envelope_ramp

Overview:
- Parametrised successor to the stepped oscillator envelope: an N-stage gain envelope that ramps linearly toward each stage's target gain instead of stepping to it.
- Adds gate-driven sustain, release and optional looping.
- Sits between the wavegen command/envelope registers and the oscillator amplitude multiplier; one instance per oscillator.
- Advances only on sample_tick (48 kHz); the fast clock is used for a per-stage step division.

Parameters:
- N_STAGES, 8, number of envelope stages (≥2)
- GAIN_W, 8, width of stage gain targets
- DUR_W, 32, width of stage duration, in samples
- FRAC_W, 16, fractional bits of the internal level/output

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sample_tick  in  1  one-cycle pulse per output sample; spacing ≥ GAIN_W+FRAC_W+4 clk
- gate  in  1  key held (level)
- env_reset  in  1  synchronous envelope restart request (cmds envelope-reset bit)
- gains  in  N_STAGES*GAIN_W  stage targets (unsigned), packed array [N_STAGES][GAIN_W]
- durations  in  N_STAGES*DUR_W  stage lengths in samples, packed array [N_STAGES][DUR_W]
- sustain_idx  in  $clog2(N_STAGES)  last attack/decay stage; held while gate high
- loop_en  in  1  1: wrap sustain_idx→0 while gate high instead of holding
- level  out  GAIN_W+FRAC_W  current gain, unsigned fixed point
- stage  out  $clog2(N_STAGES)  current stage index
- active  out  1  high in RAMP/SUSTAIN
- done  out  1  one-cycle pulse on entering DONE

Behaviour:
- Reset (rst or env_reset): state IDLE, level=0, stage=0, active=0, done=0, elapsed=0. Priority: rst > env_reset > gate edge > tick.
- States: IDLE, SETUP, RAMP, SUSTAIN, DONE.
- IDLE/DONE + gate rising edge (registered gate 0→1) → SETUP, stage 0, start from current level.
- SETUP:
  - Latch target T=gains[stage]<<FRAC_W and D=durations[stage]; clear elapsed.
  - If D==0: level:=T immediately and advance.
  - Otherwise start divider: step=|T−level|/D, truncated, sign kept separately.
  - Divider latency is GAIN_W+FRAC_W+1 clk; level holds until done, then → RAMP.
  - A sample_tick arriving during SETUP is counted in elapsed but does not move level.
- RAMP, per sample_tick:
  - elapsed++.
  - If elapsed==D: level:=T exactly (truncation error absorbed) and advance.
  - Otherwise level ± step, saturating at 0 and 2^(GAIN_W+FRAC_W)−1.
- Advance from stage s:
  - s==sustain_idx with gate=1 and loop_en=0 → SUSTAIN (level held at T).
  - s==sustain_idx with gate=1 and loop_en=1 → stage 0, SETUP.
  - s==N_STAGES−1 → DONE, with a 1-cycle done pulse.
  - Otherwise stage s+1, SETUP.
- Gate falling edge while stage ≤ sustain_idx (RAMP, SETUP or SUSTAIN):
  - → stage sustain_idx+1, SETUP, ramping from the current level (no jump).
  - If sustain_idx==N_STAGES−1 → DONE.
- Gate falling edge during release stages: ignored.
- Gate rising edge during release stages: restart at stage 0 from the current level.
- DONE: level holds gains[N−1]<<FRAC_W; active=0.
- Inputs gains/durations/sustain_idx are sampled only at SETUP; changes mid-stage take effect at the next stage.
- level, stage, active and done are all registered outputs.

Decomposition:
- shape_pkg/protocol_pkg: add env_state_t enum and typedef envelope_ramp_cfg_t {gains, durations, sustain_idx, loop_en}.
- constants.svh: ENVELOPE_LOOP_BIT.
- Sub-module seq_divider:
  - Restoring unsigned divider, parameters NUM_W/DEN_W.
  - Interface: start/busy/done/quotient.
  - Divide-by-zero returns all-ones; envelope_ramp never issues it.

Test Plan (GAIN_W=8, FRAC_W=16, N_STAGES=8, tick every 64 clk):
- Stage0 gain=100 dur=4, gate=1 from 0 → level after ticks 1..4 = 25,50,75,100 (<<16), stage→1 on tick 4.
- Stage0 gain=10 dur=3 (step truncates to 218453) → level after tick 3 is exactly 10<<16.
- sustain_idx=2, gains 10/20/30, gate held → SUSTAIN at 30<<16; gate low → stage 3 ramps from 30<<16 toward gains[3]=0 over durations[3]; DONE + one done pulse after stage 7.
- Gate drop mid-stage1 (level 15<<16) → stage 3, first release tick moves level down from 15<<16; no discontinuity.
- loop_en=1, sustain_idx=1 → stage sequence 0,1,0,1… while gate high; durations[1]=0 → level snaps to gains[1] with no tick consumed.
- env_reset asserted mid-RAMP → next cycle IDLE, level=0, active=0; rst at the same cycle as a gate edge → reset wins.
